// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encodings, mode-3 idle
// levels and a counter-width helper.
package spi_master_pkg;

    localparam logic SCK_IDLE = 1'b1;
    localparam logic CS_IDLE  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } spi_state_t;

    // Width of a counter that has to hold values 0..n-1 (never narrower than one bit).
    function automatic int cntWidth(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Bundle of the SPI master's parallel handshake and serial pins.
// The master modport is the controller's view; slave is the user/peripheral side.
interface spi_master_if #(
    parameter int SIZE = 40
);

    logic [SIZE-1:0] data_in;
    logic            start_in;
    logic            miso_in;
    logic [SIZE-1:0] r_data_out;
    logic            r_busy_out;
    logic            r_done_out;
    logic            r_sck_out;
    logic            r_cs_n_out;
    logic            r_mosi_out;

    modport master (
        input  data_in, start_in, miso_in,
        output r_data_out, r_busy_out, r_done_out, r_sck_out, r_cs_n_out, r_mosi_out
    );

    modport slave (
        output data_in, start_in, miso_in,
        input  r_data_out, r_busy_out, r_done_out, r_sck_out, r_cs_n_out, r_mosi_out
    );

endinterface

// File: rtl/spi_master_tick.sv
// Phase timer: counts CLK_DIV clocks per FSM phase and flags the last one.
// Held at zero while i_clear is high so every frame starts from a fresh phase.
module spi_master_tick
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic i_clear,
    output logic o_phase_end
);

    localparam int CW = cntWidth(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_count;

    assign o_phase_end = !i_clear && (r_count == LAST);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_count <= '0;
        end else if (i_clear || o_phase_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-3 SPI master: sends a SIZE-bit datagram MSB-first with CS setup/hold/gap
// phases and returns the word captured from MISO with a one-cycle done pulse.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int SIZE    = 40,
    parameter int CLK_DIV = 4
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic [SIZE-1:0] data_in,
    input  logic            start_in,
    input  logic            miso_in,
    output logic [SIZE-1:0] r_data_out,
    output logic            r_busy_out,
    output logic            r_done_out,
    output logic            r_sck_out,
    output logic            r_cs_n_out,
    output logic            r_mosi_out
);

    localparam int BW = $clog2(SIZE + 1);

    spi_state_t      r_state;
    spi_state_t      w_nextState;
    logic [SIZE-2:0] r_txShift;
    logic [SIZE-2:0] w_txShift;
    logic [SIZE-1:0] r_rxShift;
    logic [SIZE-1:0] w_rxShift;
    logic [BW-1:0]   r_bitCnt;
    logic [BW-1:0]   w_bitCnt;
    logic [SIZE-1:0] w_dataOut;
    logic            w_busy;
    logic            w_done;
    logic            w_sck;
    logic            w_csN;
    logic            w_mosi;
    logic            w_phaseEnd;

    spi_master_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_in      (clk_in),
        .reset_n_in  (reset_n_in),
        .i_clear     (r_state == ST_IDLE),
        .o_phase_end (w_phaseEnd)
    );

    // The MSB goes straight to MOSI at start; r_txShift holds only the bits still to send.
    always_comb begin
        w_nextState = r_state;
        w_txShift   = r_txShift;
        w_rxShift   = r_rxShift;
        w_bitCnt    = r_bitCnt;
        w_dataOut   = r_data_out;
        w_busy      = r_busy_out;
        w_done      = 1'b0;
        w_sck       = r_sck_out;
        w_csN       = r_cs_n_out;
        w_mosi      = r_mosi_out;

        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    w_nextState = ST_SETUP;
                    w_txShift   = data_in[SIZE-2:0];
                    w_mosi      = data_in[SIZE-1];
                    w_csN       = 1'b0;
                    w_busy      = 1'b1;
                    w_bitCnt    = '0;
                end
            end
            ST_SETUP: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_SHIFT_LO;
                    w_sck       = 1'b0;
                end
            end
            ST_SHIFT_LO: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_SHIFT_HI;
                    w_sck       = 1'b1;
                    w_rxShift   = {r_rxShift[SIZE-2:0], miso_in};
                    w_bitCnt    = r_bitCnt + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (w_phaseEnd) begin
                    if (r_bitCnt < BW'(SIZE)) begin
                        w_nextState = ST_SHIFT_LO;
                        w_sck       = 1'b0;
                        w_mosi      = r_txShift[SIZE-2];
                        w_txShift   = r_txShift << 1;
                    end else begin
                        w_nextState = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_GAP;
                    w_csN       = CS_IDLE;
                    w_mosi      = 1'b0;
                    w_dataOut   = r_rxShift;
                    w_done      = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_IDLE;
                    w_busy      = 1'b0;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_IDLE;
            r_txShift  <= '0;
            r_rxShift  <= '0;
            r_bitCnt   <= '0;
            r_data_out <= '0;
            r_busy_out <= 1'b0;
            r_done_out <= 1'b0;
            r_sck_out  <= SCK_IDLE;
            r_cs_n_out <= CS_IDLE;
            r_mosi_out <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_txShift  <= w_txShift;
            r_rxShift  <= w_rxShift;
            r_bitCnt   <= w_bitCnt;
            r_data_out <= w_dataOut;
            r_busy_out <= w_busy;
            r_done_out <= w_done;
            r_sck_out  <= w_sck;
            r_cs_n_out <= w_csN;
            r_mosi_out <= w_mosi;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: an 8-bit/CLK_DIV=2 instance for most
// scenarios and a 40-bit/CLK_DIV=4 instance for the full-width frame.
module tb_spi_master;

    localparam int SZ   = 8;
    localparam int CD   = 2;
    localparam int SZ40 = 40;
    localparam int CD40 = 4;

    // Frame timing derived from the phase sequence: setup, SIZE low/high pairs, hold, gap.
    localparam int CS_LOW8    = (2 * SZ + 2) * CD;
    localparam int BUSY8      = 1 + (2 * SZ + 3) * CD;
    localparam int CS_LOW40   = (2 * SZ40 + 2) * CD40;
    localparam int BUSY40     = 1 + (2 * SZ40 + 3) * CD40;
    localparam int WAIT_LIMIT = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8_n;
    logic rst40_n;
    logic loop8;
    logic fixMiso8;
    int   checks = 0;
    int   errors = 0;

    spi_master_if #(.SIZE(SZ))   if8 ();
    spi_master_if #(.SIZE(SZ40)) if40 ();

    assign if8.miso_in  = loop8 ? if8.r_mosi_out : fixMiso8;
    assign if40.miso_in = if40.r_mosi_out;

    spi_master #(.SIZE(SZ), .CLK_DIV(CD)) u_dut8 (
        .clk_in     (clk),
        .reset_n_in (rst8_n),
        .data_in    (if8.data_in),
        .start_in   (if8.start_in),
        .miso_in    (if8.miso_in),
        .r_data_out (if8.r_data_out),
        .r_busy_out (if8.r_busy_out),
        .r_done_out (if8.r_done_out),
        .r_sck_out  (if8.r_sck_out),
        .r_cs_n_out (if8.r_cs_n_out),
        .r_mosi_out (if8.r_mosi_out)
    );

    spi_master #(.SIZE(SZ40), .CLK_DIV(CD40)) u_dut40 (
        .clk_in     (clk),
        .reset_n_in (rst40_n),
        .data_in    (if40.data_in),
        .start_in   (if40.start_in),
        .miso_in    (if40.miso_in),
        .r_data_out (if40.r_data_out),
        .r_busy_out (if40.r_busy_out),
        .r_done_out (if40.r_done_out),
        .r_sck_out  (if40.r_sck_out),
        .r_cs_n_out (if40.r_cs_n_out),
        .r_mosi_out (if40.r_mosi_out)
    );

    // Pin monitor for the 8-bit instance: MOSI at each rising SCK, CS run lengths, done words.
    logic       prevSck8 = 1'b1;
    logic       prevCs8  = 1'b1;
    int         csLowCnt8  = 0;
    int         csHighCnt8 = 0;
    int         sckToggles8 = 0;
    logic       mosiQ8[$];
    int         csLowQ8[$];
    int         csHighQ8[$];
    logic [7:0] doneQ8[$];

    always @(negedge clk) begin
        if (if8.r_sck_out !== prevSck8) sckToggles8 <= sckToggles8 + 1;
        if (prevSck8 === 1'b0 && if8.r_sck_out === 1'b1) mosiQ8.push_back(if8.r_mosi_out);
        if (if8.r_cs_n_out === 1'b0) begin
            if (prevCs8 === 1'b1) begin
                csHighQ8.push_back(csHighCnt8);
                csHighCnt8 <= 0;
            end
            csLowCnt8 <= csLowCnt8 + 1;
        end else begin
            if (prevCs8 === 1'b0) begin
                csLowQ8.push_back(csLowCnt8);
                csLowCnt8 <= 0;
            end
            csHighCnt8 <= csHighCnt8 + 1;
        end
        if (if8.r_done_out === 1'b1) doneQ8.push_back(if8.r_data_out);
        prevSck8 <= if8.r_sck_out;
        prevCs8  <= if8.r_cs_n_out;
    end

    // Pin monitor for the 40-bit instance.
    logic        prevSck40 = 1'b1;
    logic        prevCs40  = 1'b1;
    int          csLowCnt40 = 0;
    logic        mosiQ40[$];
    int          csLowQ40[$];
    logic [39:0] doneQ40[$];

    always @(negedge clk) begin
        if (prevSck40 === 1'b0 && if40.r_sck_out === 1'b1) mosiQ40.push_back(if40.r_mosi_out);
        if (if40.r_cs_n_out === 1'b0) begin
            csLowCnt40 <= csLowCnt40 + 1;
        end else if (prevCs40 === 1'b0) begin
            csLowQ40.push_back(csLowCnt40);
            csLowCnt40 <= 0;
        end
        if (if40.r_done_out === 1'b1) doneQ40.push_back(if40.r_data_out);
        prevSck40 <= if40.r_sck_out;
        prevCs40  <= if40.r_cs_n_out;
    end

    // Reference model: the word the master must return for a given MISO source.
    function automatic logic [7:0] modelRx8(input logic [7:0] tx, input logic useLoop, input logic misoVal);
        return useLoop ? tx : {8{misoVal}};
    endfunction

    // Reassemble the MOSI bits seen at rising SCK edges into a word, MSB first.
    function automatic logic [7:0] mosiByte(input int base);
        logic [7:0] v;
        v = 'x;
        for (int i = 0; i < 8; i++)
            if (base + i < mosiQ8.size()) v[7-i] = mosiQ8[base+i];
        return v;
    endfunction

    function automatic logic [39:0] mosiWord40(input int base);
        logic [39:0] v;
        v = 'x;
        for (int i = 0; i < 40; i++)
            if (base + i < mosiQ40.size()) v[39-i] = mosiQ40[base+i];
        return v;
    endfunction

    // One start pulse, then count sampled clocks until busy falls (bounded).
    task automatic runFrame8(input logic [7:0] data, input logic useLoop, input logic misoVal,
                             output int busyEdges);
        loop8        = useLoop;
        fixMiso8     = misoVal;
        if8.data_in  = data;
        if8.start_in = 1'b1;
        @(negedge clk); #1;
        if8.start_in = 1'b0;
        busyEdges = 0;
        while (if8.r_busy_out === 1'b1 && busyEdges < WAIT_LIMIT) begin
            busyEdges++;
            @(negedge clk); #1;
        end
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic test_reset();
        int t0;
        t0 = sckToggles8;
        repeat (30) begin
            @(negedge clk); #1;
            checks++;
            if ({if8.r_cs_n_out, if8.r_sck_out, if8.r_mosi_out, if8.r_busy_out, if8.r_done_out} !== 5'b11000) begin
                errors++;
                $display("[TB] FAIL reset_pins: got cs/sck/mosi/busy/done=%b expected 11000",
                         {if8.r_cs_n_out, if8.r_sck_out, if8.r_mosi_out, if8.r_busy_out, if8.r_done_out});
            end
            checks++;
            if (if8.r_data_out !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_data: got %h expected 00", if8.r_data_out);
            end
        end
        checks++;
        if (sckToggles8 !== t0) begin
            errors++;
            $display("[TB] FAIL reset_sck_toggles: got %0d expected 0", sckToggles8 - t0);
        end
        if8.start_in = 1'b0;
        rst8_n  = 1'b1;
        rst40_n = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic test_loopback();
        int busyEdges, m0, c0, d0;
        m0 = mosiQ8.size(); c0 = csLowQ8.size(); d0 = doneQ8.size();
        runFrame8(8'b10101100, 1'b1, 1'b0, busyEdges);
        checks++;
        if (mosiQ8.size() - m0 !== SZ) begin
            errors++;
            $display("[TB] FAIL loop_edges: got %0d expected %0d", mosiQ8.size() - m0, SZ);
        end
        checks++;
        if (mosiByte(m0) !== 8'hAC) begin
            errors++;
            $display("[TB] FAIL loop_mosi: got %h expected ac", mosiByte(m0));
        end
        checks++;
        if (csLowQ8.size() - c0 !== 1 || csLowQ8[c0] !== CS_LOW8) begin
            errors++;
            $display("[TB] FAIL loop_cs_low: got %0d runs, first %0d, expected 1 run of %0d",
                     csLowQ8.size() - c0, (csLowQ8.size() > c0) ? csLowQ8[c0] : -1, CS_LOW8);
        end
        checks++;
        if (doneQ8.size() - d0 !== 1 || doneQ8[d0] !== 8'hAC) begin
            errors++;
            $display("[TB] FAIL loop_done: got %0d pulses, word %h, expected 1 pulse with ac",
                     doneQ8.size() - d0, (doneQ8.size() > d0) ? doneQ8[d0] : 8'hxx);
        end
        checks++;
        if (busyEdges + 1 !== BUSY8) begin
            errors++;
            $display("[TB] FAIL loop_busy_len: got %0d expected %0d", busyEdges + 1, BUSY8);
        end
        checks++;
        if (if8.r_data_out !== 8'hAC) begin
            errors++;
            $display("[TB] FAIL loop_data_hold: got %h expected ac", if8.r_data_out);
        end
    endtask

    task automatic test_fixed_miso();
        int busyEdges, m0, d0;
        logic [7:0] txs [2];
        logic       misos [2];
        txs[0] = 8'h00; misos[0] = 1'b1;
        txs[1] = 8'hFF; misos[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m0 = mosiQ8.size(); d0 = doneQ8.size();
            runFrame8(txs[k], 1'b0, misos[k], busyEdges);
            checks++;
            if (doneQ8.size() - d0 !== 1 || doneQ8[d0] !== modelRx8(txs[k], 1'b0, misos[k])) begin
                errors++;
                $display("[TB] FAIL fixed_done[%0d]: got %0d pulses, word %h, expected %h", k,
                         doneQ8.size() - d0, (doneQ8.size() > d0) ? doneQ8[d0] : 8'hxx,
                         modelRx8(txs[k], 1'b0, misos[k]));
            end
            checks++;
            if (mosiByte(m0) !== txs[k]) begin
                errors++;
                $display("[TB] FAIL fixed_mosi[%0d]: got %h expected %h", k, mosiByte(m0), txs[k]);
            end
        end
        fixMiso8 = 1'b0;
    endtask

    task automatic test_random_frames();
        int         busyEdges, m0, d0;
        logic [7:0] tx;
        logic       useLoop, mv;
        for (int k = 0; k < 6; k++) begin
            tx      = 8'($urandom);
            useLoop = 1'($urandom_range(0, 1));
            mv      = 1'($urandom);
            m0 = mosiQ8.size(); d0 = doneQ8.size();
            runFrame8(tx, useLoop, mv, busyEdges);
            checks++;
            if (mosiQ8.size() - m0 !== SZ || mosiByte(m0) !== tx) begin
                errors++;
                $display("[TB] FAIL rand_mosi[%0d]: got %0d edges word %h expected %0d edges word %h",
                         k, mosiQ8.size() - m0, mosiByte(m0), SZ, tx);
            end
            checks++;
            if (doneQ8.size() - d0 !== 1 || doneQ8[d0] !== modelRx8(tx, useLoop, mv)) begin
                errors++;
                $display("[TB] FAIL rand_done[%0d]: got %0d pulses word %h expected %h", k,
                         doneQ8.size() - d0, (doneQ8.size() > d0) ? doneQ8[d0] : 8'hxx,
                         modelRx8(tx, useLoop, mv));
            end
            checks++;
            if (busyEdges + 1 !== BUSY8) begin
                errors++;
                $display("[TB] FAIL rand_busy_len[%0d]: got %0d expected %0d", k, busyEdges + 1, BUSY8);
            end
        end
    endtask

    task automatic test_back_to_back();
        int m0, d0, h0, c0, n;
        m0 = mosiQ8.size(); d0 = doneQ8.size(); h0 = csHighQ8.size(); c0 = csLowQ8.size();
        loop8        = 1'b1;
        if8.data_in  = 8'h3C;
        if8.start_in = 1'b1;
        n = 0;
        while (mosiQ8.size() - m0 < 3 && n < WAIT_LIMIT) begin n++; @(negedge clk); #1; end
        if8.data_in = 8'hC3;
        n = 0;
        while (doneQ8.size() - d0 < 2 && n < WAIT_LIMIT) begin n++; @(negedge clk); #1; end
        if8.start_in = 1'b0;
        n = 0;
        while (if8.r_busy_out === 1'b1 && n < WAIT_LIMIT) begin n++; @(negedge clk); #1; end
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if (mosiQ8.size() - m0 !== 2 * SZ || mosiByte(m0) !== 8'h3C || mosiByte(m0 + SZ) !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL b2b_mosi: got %0d edges words %h %h expected 16 edges 3c c3",
                     mosiQ8.size() - m0, mosiByte(m0), mosiByte(m0 + SZ));
        end
        checks++;
        if (doneQ8.size() - d0 !== 2 || doneQ8[d0] !== 8'h3C || doneQ8[d0+1] !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL b2b_done: got %0d pulses expected 2 pulses 3c c3", doneQ8.size() - d0);
        end
        checks++;
        if (csHighQ8.size() - h0 !== 2 || csHighQ8[h0+1] !== CD + 1) begin
            errors++;
            $display("[TB] FAIL b2b_cs_gap: got %0d gaps, gap %0d, expected %0d",
                     csHighQ8.size() - h0, (csHighQ8.size() > h0 + 1) ? csHighQ8[h0+1] : -1, CD + 1);
        end
        checks++;
        if (csLowQ8.size() - c0 !== 2 || csLowQ8[c0] !== CS_LOW8 || csLowQ8[c0+1] !== CS_LOW8) begin
            errors++;
            $display("[TB] FAIL b2b_cs_low: got %0d runs expected 2 runs of %0d", csLowQ8.size() - c0, CS_LOW8);
        end
    endtask

    task automatic test_async_reset();
        int m0, d0, n, busyEdges;
        m0 = mosiQ8.size(); d0 = doneQ8.size();
        loop8        = 1'b1;
        if8.data_in  = 8'($urandom);
        if8.start_in = 1'b1;
        @(negedge clk); #1;
        if8.start_in = 1'b0;
        n = 0;
        while (mosiQ8.size() - m0 < 3 && n < WAIT_LIMIT) begin n++; @(negedge clk); #1; end
        checks++;
        if (mosiQ8.size() - m0 !== 3) begin
            errors++;
            $display("[TB] FAIL areset_reach_edge3: got %0d edges expected 3", mosiQ8.size() - m0);
        end
        #2;
        rst8_n = 1'b0;
        #1;
        checks++;
        if ({if8.r_cs_n_out, if8.r_sck_out, if8.r_mosi_out, if8.r_busy_out, if8.r_done_out} !== 5'b11000
            || if8.r_data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got pins %b data %h expected 11000 data 00",
                     {if8.r_cs_n_out, if8.r_sck_out, if8.r_mosi_out, if8.r_busy_out, if8.r_done_out},
                     if8.r_data_out);
        end
        repeat (3) begin @(negedge clk); #1; end
        rst8_n = 1'b1;
        repeat (4) begin @(negedge clk); #1; end
        checks++;
        if (doneQ8.size() !== d0) begin
            errors++;
            $display("[TB] FAIL areset_no_done: got %0d pulses expected 0", doneQ8.size() - d0);
        end
        m0 = mosiQ8.size(); d0 = doneQ8.size();
        runFrame8(8'h5A, 1'b1, 1'b0, busyEdges);
        checks++;
        if (doneQ8.size() - d0 !== 1 || doneQ8[d0] !== 8'h5A || mosiByte(m0) !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL areset_recover: got %0d pulses word %h mosi %h expected 5a",
                     doneQ8.size() - d0, (doneQ8.size() > d0) ? doneQ8[d0] : 8'hxx, mosiByte(m0));
        end
    endtask

    task automatic test_size40();
        int          m0, c0, d0, busyEdges;
        logic [63:0] r64;
        logic [39:0] txs [2];
        r64    = {$urandom, $urandom};
        txs[0] = 40'h80_0000_0001;
        txs[1] = r64[39:0];
        for (int k = 0; k < 2; k++) begin
            m0 = mosiQ40.size(); c0 = csLowQ40.size(); d0 = doneQ40.size();
            if40.data_in  = txs[k];
            if40.start_in = 1'b1;
            @(negedge clk); #1;
            if40.start_in = 1'b0;
            busyEdges = 0;
            while (if40.r_busy_out === 1'b1 && busyEdges < WAIT_LIMIT) begin
                busyEdges++;
                @(negedge clk); #1;
            end
            repeat (2) begin @(negedge clk); #1; end
            checks++;
            if (mosiQ40.size() - m0 !== SZ40 || mosiWord40(m0) !== txs[k]) begin
                errors++;
                $display("[TB] FAIL w40_mosi[%0d]: got %0d edges word %h expected %0d edges word %h",
                         k, mosiQ40.size() - m0, mosiWord40(m0), SZ40, txs[k]);
            end
            checks++;
            if (csLowQ40.size() - c0 !== 1 || csLowQ40[c0] !== CS_LOW40) begin
                errors++;
                $display("[TB] FAIL w40_cs_low[%0d]: got %0d runs, first %0d, expected %0d", k,
                         csLowQ40.size() - c0, (csLowQ40.size() > c0) ? csLowQ40[c0] : -1, CS_LOW40);
            end
            checks++;
            if (doneQ40.size() - d0 !== 1 || doneQ40[d0] !== txs[k]) begin
                errors++;
                $display("[TB] FAIL w40_done[%0d]: got %0d pulses word %h expected %h", k,
                         doneQ40.size() - d0, (doneQ40.size() > d0) ? doneQ40[d0] : 40'hx, txs[k]);
            end
            checks++;
            if (busyEdges + 1 !== BUSY40) begin
                errors++;
                $display("[TB] FAIL w40_busy_len[%0d]: got %0d expected %0d", k, busyEdges + 1, BUSY40);
            end
        end
    endtask

    initial begin
        rst8_n        = 1'b0;
        rst40_n       = 1'b0;
        loop8         = 1'b1;
        fixMiso8      = 1'b0;
        if8.start_in  = 1'b1;
        if8.data_in   = 8'($urandom);
        if40.start_in = 1'b0;
        if40.data_in  = '0;

        test_reset();
        test_loopback();
        test_fixed_miso();
        test_random_frames();
        test_back_to_back();
        test_async_reset();
        test_size40();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck design so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Serial link controller between the stepper core's register logic and the external driver IC's SPI port.
- Accepts a parallel datagram on a start strobe, then drives chip select, SCK and MOSI MSB-first.
- Captures MISO into a parallel word and returns it with a done pulse.
- SPI mode 3: SCK idles high; MOSI changes on falling edges; MISO is sampled on rising edges.

Parameters:
SIZE, 40, datagram width in bits (min 2)
CLK_DIV, 4, clk_in cycles per SCK half-period and per CS setup/hold/gap phase (min 1)

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  reset; asynchronous, active-low
data_in  input  SIZE  datagram to transmit; sampled only on accepted start
start_in  input  1  start request; honoured only in IDLE
miso_in  input  1  serial data from slave
r_data_out  output  SIZE  last received datagram
r_busy_out  output  1  high from accepted start until return to IDLE
r_done_out  output  1  one-cycle pulse when the received word is valid
r_sck_out  output  1  serial clock
r_cs_n_out  output  1  chip select, active-low
r_mosi_out  output  1  serial data to slave

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on reset_n_in. All outputs are registered.
- Reset values (applied immediately on reset_n_in low, including mid-transfer):
  - r_cs_n_out=1, r_sck_out=1, r_mosi_out=0
  - r_busy_out=0, r_done_out=0, r_data_out=0
  - FSM=IDLE, all counters=0
- FSM states: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP.
  - One phase counter counts CLK_DIV cycles per phase.
  - One bit counter of width $clog2(SIZE+1).
- IDLE: start_in=1 at a clock edge causes, on that edge:
  - tx shift register <= data_in
  - r_mosi_out <= data_in[SIZE-1]
  - r_cs_n_out <= 0, r_busy_out <= 1
  - next state SETUP
- SETUP (CLK_DIV cycles, SCK high) -> SHIFT_LO, with r_sck_out <= 0.
  - The first falling edge does not change MOSI.
- SHIFT_LO (CLK_DIV cycles) -> SHIFT_HI:
  - r_sck_out <= 1
  - rx <= {rx[SIZE-2:0], miso_in}
  - bit counter increments
- SHIFT_HI (CLK_DIV cycles):
  - If bit counter < SIZE -> SHIFT_LO: r_sck_out <= 0, tx shifts left, r_mosi_out <= next bit.
  - Else -> HOLD, SCK stays high.
- HOLD (CLK_DIV cycles) -> GAP:
  - r_cs_n_out <= 1, r_mosi_out <= 0
  - r_data_out <= rx; r_done_out = 1 for exactly this one cycle
- GAP (CLK_DIV cycles, CS high) -> IDLE with r_busy_out <= 0.
  - Guarantees minimum CS-high time between frames.
- Exactly SIZE rising SCK edges per frame; MOSI is stable across every rising edge.
- CS low duration = (2*SIZE+2)*CLK_DIV cycles.
- Start-to-busy-low = 1+(2*SIZE+3)*CLK_DIV cycles.
- start_in outside IDLE is ignored and not queued; data_in changes during a frame have no effect.
- start_in held high continuously gives back-to-back frames separated by GAP plus one IDLE cycle.
- r_data_out holds its value until the next done pulse.

Decomposition:
- Include file spi_defs.v holds the FSM state encodings (3-bit localparams) and the mode-3 idle levels (SCK_IDLE=1, CS_IDLE=1).
- Sub-module spi_tick is natural: a CLK_DIV phase counter with load/clear, emitting a one-cycle phase_end pulse. The FSM advances only on phase_end.
- The rx path stays inline; no sipo instance.

Test Plan (SIZE=8, CLK_DIV=2 unless noted):
1. reset_n_in low 30 clocks, start_in=1 throughout -> cs_n=1, sck=1, mosi=0, busy=0, done=0, data_out=0x00; no SCK toggles.
2. miso_in looped to r_mosi_out, data_in=8'b10101100, start for 1 cycle ->
   - MOSI at the 8 rising SCK edges = 1,0,1,0,1,1,0,0
   - exactly 8 rising edges; cs_n low 36 cycles
   - done pulse 1 cycle with data_out=0xAC; busy low 39 cycles after the start edge
3. miso_in tied 1, data_in=0x00 -> data_out=0xFF; then miso_in tied 0, data_in=0xFF -> data_out=0x00; MOSI all 1 in the second frame.
4. start_in held high, data_in switched from 0x3C to 0xC3 mid-frame ->
   - first frame transmits 0x3C
   - cs_n high ≥2 cycles between frames
   - second frame transmits 0xC3; exactly one done per frame
5. reset_n_in pulled low asynchronously after the 3rd rising SCK edge ->
   - outputs take reset values without waiting for a clock edge; no done pulse
   - after release, a start with data_in=0x5A in loopback completes with data_out=0x5A
6. SIZE=40, CLK_DIV=4, loopback, data_in=40'h80_0000_0001 -> 40 rising edges; cs_n low 328 cycles; data_out=40'h80_0000_0001.
